cpu_mem_rw_seq: RTL and testbench
=================================

Name: cpu_mem_rw_seq

Overview:
- Parametrised successor to the CPU read/write microcode functions.
- Runs a complete memory read or write on the motherboard bus as a single call:
  - single-beat or burst transfers;
  - per-beat request/acknowledge handshake;
  - bus-error and timeout detection.
- Sits between the CPU state sequencer (caller) and the motherboard bus.
- Reports completion with a one-cycle done pulse, so the caller can perform its function return.

Parameters:
- WORD_WIDTH, 32, data word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- MAX_BURST, 8, maximum beats per call; power of 2, at least 2.
- LEN_W, $clog2(MAX_BURST), width of the length field.
- TIMEOUT, 255, maximum cycles a strobe may wait for ack/err; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  caller requests a call
- req_ready  out  1  block can accept a call
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  start byte address, word aligned
- req_len  in  LEN_W  beats minus 1
- wr_data  in  WORD_WIDTH  write data for the current beat
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  block takes wr_data this cycle
- rd_data  out  WORD_WIDTH  read data for the current beat
- rd_valid  out  1  rd_data is valid; one-cycle pulse per beat
- done  out  1  call complete; one-cycle pulse
- err  out  1  status of the last call; held until the next accept
- err_code  out  2  00 ok, 01 bus_err, 10 timeout
- beats_done  out  LEN_W+1  beats completed in the last call
- bus_addr  out  ADDR_WIDTH  bus address
- bus_wdata  out  WORD_WIDTH  bus write data
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_rdata  in  WORD_WIDTH  bus read data
- bus_ack  in  1  beat accepted or completed
- bus_err  in  1  beat failed

Behaviour:
- States: IDLE, FETCH, STROBE, GAP, DONE.
- Reset values: all outputs 0 except req_ready = 1; state = IDLE; counters = 0.
- Reset mid-call: strobes drop in the same cycle reset is sampled; no done pulse is issued.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, latch addr, len and write; clear err, err_code and beats_done.
  - Write goes to FETCH; read goes to STROBE.
- FETCH (write only):
  - wr_ready = 1.
  - When wr_valid is high, capture wr_data into bus_wdata and go to STROBE.
  - No timeout in this state; it waits indefinitely.
- STROBE:
  - bus_rd or bus_wr held high; bus_addr and bus_wdata held stable.
  - Timeout counter increments every cycle and resets at each STROBE entry.
- Precedence in STROBE:
  - bus_err has priority over bus_ack when both are high.
  - A timeout is declared when the counter reaches TIMEOUT with no ack or err: go to DONE with err_code = 10.
- On bus_ack:
  - Read: rd_data <= bus_rdata and rd_valid pulses in the next cycle.
  - beats_done increments.
  - bus_addr increments by WORD_WIDTH/8, wrapping modulo 2^ADDR_WIDTH with no error.
  - If the beat was the last (beats_done == len+1 after increment), go to DONE; otherwise go to GAP.
- On bus_err: go to DONE with err = 1 and err_code = 01; remaining beats are abandoned.
- GAP:
  - Strobes low for exactly one cycle (minimum spacing between bus beats).
  - Then FETCH for a write, STROBE for a read.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - req_ready stays 0 in DONE, so back-to-back calls have at least one cycle between them.
- Latency: a single-beat read with ack in the first strobe cycle gives accept → strobe 1 cycle → done 2 cycles after the strobe.
- Outside IDLE, req_valid is ignored.
- Outside FETCH, wr_ready = 0 and wr_valid is ignored.

Test Plan:
- Single read: addr 0x100, len 0, ack on the 3rd strobe cycle with rdata 0xDEADBEEF → bus_rd high for 3 cycles, rd_valid with 0xDEADBEEF, done, err=0, beats_done=1.
- Write burst: len 3 from 0x200 with data 0x11, 0x22, 0x33, 0x44; wr_valid delayed 2 cycles on beat 2 → addrs 0x200/204/208/20C, one GAP cycle between strobes, beats_done=4.
- Bus error: read len 7, bus_err on beat 3 → done with err_code=01, beats_done=2, no further strobes; ack and err asserted together → treated as err.
- Timeout: TIMEOUT=4, no ack → strobe held 4 cycles, done with err_code=10; the next call is accepted and clears err.
- Address wrap: ADDR_WIDTH=8, addr 0xFC, len 1 → second beat at 0x00, no error.
- Reset mid-burst: rst during STROBE of beat 2 → strobes low the next cycle, req_ready=1, no done pulse.

Source files
------------

// File: rtl/cpu_mem_rw_seq.sv
// Memory read/write call sequencer between the CPU state sequencer and the motherboard bus.
// One accepted call runs 1..MAX_BURST beats with per-beat strobe/ack, bus-error and timeout handling.
module cpu_mem_rw_seq #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int LEN_W      = $clog2(MAX_BURST),
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [LEN_W:0]        beats_done,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WORD_WIDTH-1:0] bus_wdata,
  output logic                  bus_rd,
  output logic                  bus_wr,
  input  logic [WORD_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  output logic [2:0]            dbg_state
);

  // Handshake: req_valid && req_ready accepts a call; wr_valid && wr_ready transfers one
  // write word; a beat completes on the clock edge that samples bus_ack or bus_err high
  // while a strobe is asserted. rd_valid and done are single-cycle pulses with no back-pressure.

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TLAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(WORD_WIDTH / 8);
  localparam logic [LEN_W:0]        ONE_B = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_STROBE = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             write_q;
  logic [TW-1:0]    tcnt;
  logic [LEN_W:0]   beats_next;
  logic             last_beat;

  assign beats_next = beats_done + ONE_B;
  assign last_beat  = (beats_next == ({1'b0, len_q} + ONE_B));
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      wr_ready   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      beats_done <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_rd     <= 1'b0;
      bus_wr     <= 1'b0;
      len_q      <= '0;
      write_q    <= 1'b0;
      tcnt       <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            bus_addr   <= req_addr;
            len_q      <= req_len;
            write_q    <= req_write;
            err        <= 1'b0;
            err_code   <= 2'b00;
            beats_done <= '0;
            req_ready  <= 1'b0;
            tcnt       <= '0;
            if (req_write) begin
              wr_ready <= 1'b1;
              state    <= S_FETCH;
            end else begin
              bus_rd <= 1'b1;
              state  <= S_STROBE;
            end
          end
        end
        S_FETCH: begin
          if (wr_valid) begin
            bus_wdata <= wr_data;
            wr_ready  <= 1'b0;
            bus_wr    <= 1'b1;
            tcnt      <= '0;
            state     <= S_STROBE;
          end
        end
        S_STROBE: begin
          // Error wins over a simultaneous ack; a late ack never rescues a timed-out beat.
          if (bus_err) begin
            bus_rd   <= 1'b0;
            bus_wr   <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= S_DONE;
          end else if (bus_ack) begin
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            beats_done <= beats_next;
            bus_addr   <= bus_addr + STEP;
            if (!write_q) begin
              rd_data  <= bus_rdata;
              rd_valid <= 1'b1;
            end
            state <= last_beat ? S_DONE : S_GAP;
          end else if (tcnt == TLAST) begin
            bus_rd   <= 1'b0;
            bus_wr   <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_GAP: begin
          tcnt <= '0;
          if (write_q) begin
            wr_ready <= 1'b1;
            state    <= S_FETCH;
          end else begin
            bus_rd <= 1'b1;
            state  <= S_STROBE;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          bus_rd    <= 1'b0;
          bus_wr    <= 1'b0;
          wr_ready  <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_rw_seq.sv
// Directed bench for cpu_mem_rw_seq: a 32-bit-address instance plus an 8-bit-address
// instance fed with identical stimulus, used to observe address wrap.
module tb_cpu_mem_rw_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  logic        req_ready, wr_ready, rd_valid, done, err, bus_rd, bus_wr;
  logic [31:0] rd_data, bus_addr, bus_wdata;
  logic [1:0]  err_code;
  logic [3:0]  beats_done;
  logic [2:0]  dbg_state;

  logic        b_req_ready, b_wr_ready, b_rd_valid, b_done, b_err, b_bus_rd, b_bus_wr;
  logic [31:0] b_rd_data, b_bus_wdata;
  logic [7:0]  b_bus_addr;
  logic [1:0]  b_err_code;
  logic [3:0]  b_beats_done;
  logic [2:0]  b_dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  cpu_mem_rw_seq #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .err_code(err_code), .beats_done(beats_done), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  cpu_mem_rw_seq #(.WORD_WIDTH(32), .ADDR_WIDTH(8), .MAX_BURST(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr[7:0]), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .done(b_done), .err(b_err),
    .err_code(b_err_code), .beats_done(b_beats_done), .bus_addr(b_bus_addr),
    .bus_wdata(b_bus_wdata), .bus_rd(b_bus_rd), .bus_wr(b_bus_wr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(b_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic start_call(input logic wr, input logic [31:0] addr, input logic [2:0] len);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic supply_wr(input logic [31:0] d, input int delay, output int waited);
    waited = 0;
    while (!wr_ready && waited < 40) begin @(negedge clk); waited++; end
    repeat (delay) @(negedge clk);
    wr_valid = 1'b1; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Acts as the bus slave for one beat; answers on strobe cycle 'lat' (0 = never).
  task automatic bus_beat(input int lat, input logic give_err, input logic [31:0] rdata,
                          output int cyc, output logic [31:0] addr_a,
                          output logic [7:0] addr_b, output logic [31:0] wd);
    int w;
    w = 0; cyc = 0;
    while (!(bus_rd || bus_wr) && w < 40) begin @(negedge clk); w++; end
    addr_a = bus_addr; addr_b = b_bus_addr; wd = bus_wdata;
    while ((bus_rd || bus_wr) && cyc < 40) begin
      cyc++;
      if (cyc == lat) begin bus_ack = 1'b1; bus_err = give_err; bus_rdata = rdata; end
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if ({bus_rd, bus_wr, wr_ready, rd_valid, done, err} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {bus_rd, bus_wr, wr_ready, rd_valid, done, err}); else pass_cnt++;
    total_cnt++; if ({err_code, beats_done, bus_addr} !== 38'h0)
      $display("FAIL reset_regs: got code=%0d beats=%0d addr=%h want 0", err_code, beats_done, bus_addr); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int cyc; logic [31:0] a, wd; logic [7:0] ab;
    start_call(1'b0, 32'h100, 3'd0);
    total_cnt++; if (bus_rd !== 1'b1 || bus_addr !== 32'h100 || req_ready !== 1'b0)
      $display("FAIL rd1_strobe: got rd=%b addr=%h ready=%b want 1 100 0", bus_rd, bus_addr, req_ready); else pass_cnt++;
    bus_beat(3, 1'b0, 32'hDEADBEEF, cyc, a, ab, wd);
    total_cnt++; if (cyc !== 3) $display("FAIL rd1_strobe_len: got %0d want 3", cyc); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || done !== 1'b0)
      $display("FAIL rd1_data: got v=%b d=%h done=%b want 1 deadbeef 0", rd_valid, rd_data, done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b0 || beats_done !== 4'd1 || rd_valid !== 1'b0)
      $display("FAIL rd1_done: got done=%b err=%b beats=%0d v=%b want 1 0 1 0", done, err, beats_done, rd_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rd1_done_pulse: got done=%b ready=%b want 0 1", done, req_ready); else pass_cnt++;
  endtask

  task automatic test_write_burst();
    logic [31:0] tab [4];
    int cyc, w; logic [31:0] a, wd; logic [7:0] ab;
    tab = '{32'h11, 32'h22, 32'h33, 32'h44};
    start_call(1'b1, 32'h200, 3'd3);
    for (int i = 0; i < 4; i++) begin
      supply_wr(tab[i], (i == 1) ? 2 : 0, w);
      total_cnt++; if (w !== ((i == 0) ? 0 : 1)) $display("FAIL wr_gap_%0d: got %0d want %0d", i, w, (i == 0) ? 0 : 1); else pass_cnt++;
      bus_beat(1, 1'b0, 32'h0, cyc, a, ab, wd);
      total_cnt++; if (cyc !== 1 || a !== 32'h200 + 32'(4 * i))
        $display("FAIL wr_addr_%0d: got cyc=%0d addr=%h want 1 %h", i, cyc, a, 32'h200 + 32'(4 * i)); else pass_cnt++;
      total_cnt++; if (wd !== tab[i]) $display("FAIL wr_data_%0d: got %h want %h", i, wd, tab[i]); else pass_cnt++;
      total_cnt++; if (bus_wr !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0)
        $display("FAIL wr_after_%0d: got wr=%b wrdy=%b rv=%b want 0 0 0", i, bus_wr, wr_ready, rd_valid); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b0 || beats_done !== 4'd4)
      $display("FAIL wr_done: got done=%b err=%b beats=%0d want 1 0 4", done, err, beats_done); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_bus_error();
    logic [31:0] tab [3];
    int cyc, s; logic [31:0] a, wd; logic [7:0] ab;
    tab = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    start_call(1'b0, 32'h300, 3'd7);
    for (int i = 0; i < 3; i++) begin
      bus_beat((i == 1) ? 2 : 1, (i == 2), tab[i], cyc, a, ab, wd);
      total_cnt++; if (a !== 32'h300 + 32'(4 * i)) $display("FAIL be_addr_%0d: got %h want %h", i, a, 32'h300 + 32'(4 * i)); else pass_cnt++;
      if (i < 2) begin
        total_cnt++; if (rd_valid !== 1'b1 || rd_data !== tab[i])
          $display("FAIL be_rdata_%0d: got v=%b d=%h want 1 %h", i, rd_valid, rd_data, tab[i]); else pass_cnt++;
      end else begin
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL be_no_rdata: got %b want 0", rd_valid); else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b1 || err_code !== 2'b01 || beats_done !== 4'd2)
      $display("FAIL be_done: got done=%b err=%b code=%b beats=%0d want 1 1 01 2", done, err, err_code, beats_done); else pass_cnt++;
    s = 0;
    repeat (5) begin @(negedge clk); if (bus_rd || bus_wr) s++; end
    total_cnt++; if (s !== 0) $display("FAIL be_no_more_strobes: got %0d want 0", s); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int cyc; logic [31:0] a, wd; logic [7:0] ab;
    start_call(1'b0, 32'h400, 3'd0);
    bus_beat(0, 1'b0, 32'h0, cyc, a, ab, wd);
    total_cnt++; if (cyc !== 4) $display("FAIL to_strobe_len: got %0d want 4", cyc); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b1 || err_code !== 2'b10 || beats_done !== 4'd0)
      $display("FAIL to_done: got done=%b err=%b code=%b beats=%0d want 1 1 10 0", done, err, err_code, beats_done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (err !== 1'b1 || err_code !== 2'b10) $display("FAIL to_err_held: got err=%b code=%b want 1 10", err, err_code); else pass_cnt++;
    start_call(1'b0, 32'h404, 3'd0);
    total_cnt++; if (err !== 1'b0 || err_code !== 2'b00 || bus_rd !== 1'b1)
      $display("FAIL to_next_clears: got err=%b code=%b rd=%b want 0 00 1", err, err_code, bus_rd); else pass_cnt++;
    bus_beat(1, 1'b0, 32'h5555_AAAA, cyc, a, ab, wd);
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b0 || beats_done !== 4'd1)
      $display("FAIL to_next_done: got done=%b err=%b beats=%0d want 1 0 1", done, err, beats_done); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    int cyc; logic [31:0] a, wd; logic [7:0] ab;
    start_call(1'b0, 32'hFC, 3'd1);
    bus_beat(1, 1'b0, 32'h1, cyc, a, ab, wd);
    total_cnt++; if (ab !== 8'hFC) $display("FAIL wrap_beat0: got %h want fc", ab); else pass_cnt++;
    bus_beat(1, 1'b0, 32'h2, cyc, a, ab, wd);
    total_cnt++; if (ab !== 8'h00 || a !== 32'h100) $display("FAIL wrap_beat1: got b=%h a=%h want 00 100", ab, a); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (b_done !== 1'b1 || b_err !== 1'b0 || b_beats_done !== 4'd2)
      $display("FAIL wrap_done: got done=%b err=%b beats=%0d want 1 0 2", b_done, b_err, b_beats_done); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int cyc, w, d; logic [31:0] a, wd; logic [7:0] ab;
    start_call(1'b0, 32'h500, 3'd3);
    bus_beat(1, 1'b0, 32'h9, cyc, a, ab, wd);
    w = 0;
    while (!bus_rd && w < 40) begin @(negedge clk); w++; end
    total_cnt++; if (bus_rd !== 1'b1 || bus_addr !== 32'h504)
      $display("FAIL rst_beat2_strobe: got rd=%b addr=%h want 1 504", bus_rd, bus_addr); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (bus_rd !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || beats_done !== 4'd0)
      $display("FAIL rst_mid: got rd=%b ready=%b done=%b beats=%0d want 0 1 0 0", bus_rd, req_ready, done, beats_done); else pass_cnt++;
    d = 0;
    repeat (4) begin @(negedge clk); if (done || bus_rd) d++; end
    total_cnt++; if (d !== 0) $display("FAIL rst_no_done: got %0d want 0", d); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 1'b0; bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_burst();
    test_bus_error();
    test_timeout();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
